// File: rtl/encoder_4_motor_receiver.sv
// encoder_4_motor_receiver: receive end of the 4-motor encoder link.
// 8N1 UART receiver feeding a frame parser for 0xFF, E1, E2, E3, E4 frames.
// E1..E4 update only on a good frame, with a one-cycle FRAME_VALID strobe;
// aborted frames (bad stop bit or inter-byte timeout) give a FRAME_ERR strobe.
module encoder_4_motor_receiver #(
   parameter int CLKS_PER_BIT = 434,
   parameter int TIMEOUT_BITS = 20
) (
   input  logic       CLK,
   input  logic       RST,
   input  logic       RX,
   output logic [7:0] E1,
   output logic [7:0] E2,
   output logic [7:0] E3,
   output logic [7:0] E4,
   output logic       FRAME_VALID,
   output logic       FRAME_ERR
);

   localparam int HALF_BIT = CLKS_PER_BIT / 2;
   localparam int TO_LIMIT = TIMEOUT_BITS * CLKS_PER_BIT;
   localparam int CW       = $clog2(CLKS_PER_BIT + 1);
   localparam int TW       = $clog2(TO_LIMIT + 1);

   typedef enum logic [1:0] {IDLE, START, DATA, STOP} ustate_t;
   typedef enum logic [2:0] {HUNT, B1, B2, B3, B4} fstate_t;

   logic          rx_meta, rxs;
   ustate_t       ustate, ustate_nxt;
   logic [CW-1:0] clk_cnt, clk_cnt_nxt;
   logic [2:0]    bit_cnt, bit_cnt_nxt;
   logic [7:0]    shreg, shreg_nxt;
   logic          byte_ok, byte_err;

   fstate_t       fstate, fstate_nxt;
   logic [7:0]    s1, s2, s3, s1_nxt, s2_nxt, s3_nxt;
   logic [TW-1:0] to_cnt, to_cnt_nxt;
   logic [7:0]    e1_nxt, e2_nxt, e3_nxt, e4_nxt;
   logic          fv_nxt, fe_nxt;

   // Two-flop synchroniser plus UART receiver state registers
   always_ff @(posedge CLK) begin
      if (RST) begin
         rx_meta <= 1'b1;
         rxs     <= 1'b1;
         ustate  <= IDLE;
         clk_cnt <= '0;
         bit_cnt <= '0;
         shreg   <= '0;
      end else begin
         rx_meta <= RX;
         rxs     <= rx_meta;
         ustate  <= ustate_nxt;
         clk_cnt <= clk_cnt_nxt;
         bit_cnt <= bit_cnt_nxt;
         shreg   <= shreg_nxt;
      end
   end

   // UART receiver next-state; byte_ok/byte_err fire in the stop-bit sample cycle
   always_comb begin
      ustate_nxt  = ustate;
      clk_cnt_nxt = clk_cnt;
      bit_cnt_nxt = bit_cnt;
      shreg_nxt   = shreg;
      byte_ok     = 1'b0;
      byte_err    = 1'b0;
      case (ustate)
         IDLE: begin
            clk_cnt_nxt = '0;
            bit_cnt_nxt = '0;
            if (!rxs) ustate_nxt = START;
         end
         START: begin
            if (clk_cnt == CW'(HALF_BIT - 1)) begin
               clk_cnt_nxt = '0;
               ustate_nxt  = rxs ? IDLE : DATA;
            end else begin
               clk_cnt_nxt = clk_cnt + CW'(1);
            end
         end
         DATA: begin
            if (clk_cnt == CW'(CLKS_PER_BIT - 1)) begin
               clk_cnt_nxt = '0;
               shreg_nxt   = {rxs, shreg[7:1]};
               if (bit_cnt == 3'd7) ustate_nxt = STOP;
               else                 bit_cnt_nxt = bit_cnt + 3'd1;
            end else begin
               clk_cnt_nxt = clk_cnt + CW'(1);
            end
         end
         STOP: begin
            if (clk_cnt == CW'(CLKS_PER_BIT - 1)) begin
               clk_cnt_nxt = '0;
               ustate_nxt  = IDLE;
               byte_ok     = rxs;
               byte_err    = !rxs;
            end else begin
               clk_cnt_nxt = clk_cnt + CW'(1);
            end
         end
         default: ustate_nxt = IDLE;
      endcase
   end

   // Frame parser registers and registered outputs
   always_ff @(posedge CLK) begin
      if (RST) begin
         fstate      <= HUNT;
         s1          <= '0;
         s2          <= '0;
         s3          <= '0;
         to_cnt      <= '0;
         E1          <= '0;
         E2          <= '0;
         E3          <= '0;
         E4          <= '0;
         FRAME_VALID <= 1'b0;
         FRAME_ERR   <= 1'b0;
      end else begin
         fstate      <= fstate_nxt;
         s1          <= s1_nxt;
         s2          <= s2_nxt;
         s3          <= s3_nxt;
         to_cnt      <= to_cnt_nxt;
         E1          <= e1_nxt;
         E2          <= e2_nxt;
         E3          <= e3_nxt;
         E4          <= e4_nxt;
         FRAME_VALID <= fv_nxt;
         FRAME_ERR   <= fe_nxt;
      end
   end

   // Frame parser next-state: header hunt, four payload slots, abort on error/timeout.
   // The timeout counter defaults to zero, so any cycle outside UART IDLE clears it.
   always_comb begin
      fstate_nxt = fstate;
      s1_nxt     = s1;
      s2_nxt     = s2;
      s3_nxt     = s3;
      to_cnt_nxt = '0;
      e1_nxt     = E1;
      e2_nxt     = E2;
      e3_nxt     = E3;
      e4_nxt     = E4;
      fv_nxt     = 1'b0;
      fe_nxt     = 1'b0;
      if (fstate == HUNT) begin
         if (byte_ok && shreg == 8'hFF) fstate_nxt = B1;
      end else if (byte_err) begin
         fe_nxt     = 1'b1;
         fstate_nxt = HUNT;
      end else if (byte_ok) begin
         case (fstate)
            B1: begin s1_nxt = shreg; fstate_nxt = B2; end
            B2: begin s2_nxt = shreg; fstate_nxt = B3; end
            B3: begin s3_nxt = shreg; fstate_nxt = B4; end
            default: begin
               e1_nxt     = s1;
               e2_nxt     = s2;
               e3_nxt     = s3;
               e4_nxt     = shreg;
               fv_nxt     = 1'b1;
               fstate_nxt = HUNT;
            end
         endcase
      end else if (ustate == IDLE) begin
         if (to_cnt == TW'(TO_LIMIT - 1)) begin
            fe_nxt     = 1'b1;
            fstate_nxt = HUNT;
         end else begin
            to_cnt_nxt = to_cnt + TW'(1);
         end
      end
   end

endmodule

// File: tb/tb_encoder_4_motor_receiver.sv
// Testbench for encoder_4_motor_receiver: table-driven frame vectors,
// hand-written timeout/glitch/reset sequences, and random byte streams
// checked against a frame-scanning reference model.
module tb_encoder_4_motor_receiver;

   localparam int CPB = 16;
   localparam int TOB = 20;

   logic       CLK = 1'b0;
   logic       RST = 1'b1;
   logic       RX  = 1'b1;
   logic [7:0] E1, E2, E3, E4;
   logic       FRAME_VALID, FRAME_ERR;

   encoder_4_motor_receiver #(.CLKS_PER_BIT(CPB), .TIMEOUT_BITS(TOB)) dut (
      .CLK(CLK), .RST(RST), .RX(RX),
      .E1(E1), .E2(E2), .E3(E3), .E4(E4),
      .FRAME_VALID(FRAME_VALID), .FRAME_ERR(FRAME_ERR)
   );

   always #5 CLK = ~CLK;

   int checks = 0;
   int failures = 0;
   int cyc = 0;
   int n_valid = 0;
   int n_err = 0;
   int last_valid_cyc = 0;
   int last_err_cyc = 0;
   int last_send_end = 0;
   logic [31:0] got_q[$];
   logic [31:0] exp_q[$];
   logic [31:0] exp_cur = '0;

   logic [7:0] stim_b[$];
   bit         stim_bad[$];
   int         stim_gap[$];

   typedef struct {
      int               n;
      logic [0:11][7:0] b;
      logic [0:11]      bad;
      int               gap;
      int               ev;
      int               ee;
      logic [31:0]      exp_e;
   } vec_t;
   vec_t vecs[5];

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%h expected=%h", name, got, exp);
      end
   endtask

   // Output monitor: counts pulses and captures E1..E4 on each FRAME_VALID
   always @(negedge CLK) begin
      cyc++;
      if (!RST && (FRAME_VALID || FRAME_ERR)) begin
         check("pulse_excl", {31'd0, FRAME_VALID & FRAME_ERR}, 32'd0);
         if (FRAME_VALID) begin
            n_valid++;
            got_q.push_back({E1, E2, E3, E4});
            last_valid_cyc = cyc;
         end
         if (FRAME_ERR) begin
            n_err++;
            last_err_cyc = cyc;
         end
      end
   end

   task automatic idle_bits(input int n);
      RX = 1'b1;
      repeat (n * CPB) @(negedge CLK);
   endtask

   task automatic send_byte(input logic [7:0] b, input bit stop_ok);
      RX = 1'b0;
      repeat (CPB) @(negedge CLK);
      for (int i = 0; i < 8; i++) begin
         RX = b[i];
         repeat (CPB) @(negedge CLK);
      end
      RX = stop_ok;
      repeat (CPB) @(negedge CLK);
      last_send_end = cyc;
      RX = 1'b1;
      if (!stop_ok) idle_bits(2);
   endtask

   task automatic run_stream(output int dv, output int de);
      int v0, e0;
      v0 = n_valid;
      e0 = n_err;
      got_q.delete();
      foreach (stim_b[i]) begin
         send_byte(stim_b[i], !stim_bad[i]);
         idle_bits(stim_gap[i]);
      end
      idle_bits(TOB + 5);
      dv = n_valid - v0;
      de = n_err - e0;
   endtask

   task automatic send_frame(input logic [31:0] f);
      send_byte(8'hFF, 1'b1);
      for (int i = 3; i >= 0; i--) send_byte(f[i*8 +: 8], 1'b1);
   endtask

   // Reference model: scan for a good 0xFF header, then require four good bytes.
   // A bad stop byte aborts the frame; a stream ending mid-frame times out.
   task automatic model(output int ee);
      int i, k, n;
      logic [31:0] f;
      ee = 0;
      exp_q.delete();
      n = stim_b.size();
      i = 0;
      while (i < n) begin
         if (!stim_bad[i] && stim_b[i] == 8'hFF) begin
            k = 1;
            f = '0;
            while (k <= 4 && i + k < n && !stim_bad[i+k]) begin
               f = {f[23:0], stim_b[i+k]};
               k++;
            end
            if (k == 5) begin
               exp_q.push_back(f);
               i = i + 5;
            end else if (i + k < n) begin
               ee++;
               i = i + k + 1;
            end else begin
               ee++;
               i = n;
            end
         end else begin
            i++;
         end
      end
   endtask

   initial begin
      #3_000_000;
      $display("FAIL watchdog time limit reached");
      $fatal(1);
   end

   initial begin
      int dv, de, ee, diff;

      vecs[0] = '{n:5,  b:{8'hFF, 8'h12, 8'h34, 8'h56, 8'h78, 56'h0}, bad:12'h000,
                  gap:1, ev:1, ee:0, exp_e:32'h12345678};
      vecs[1] = '{n:7,  b:{8'h00, 8'h7F, 8'hFF, 8'hFF, 8'h01, 8'hFF, 8'h02, 40'h0}, bad:12'h000,
                  gap:1, ev:1, ee:0, exp_e:32'hFF01FF02};
      vecs[2] = '{n:4,  b:{8'hFF, 8'hAA, 8'hBB, 8'hCC, 64'h0}, bad:12'b000100000000,
                  gap:1, ev:0, ee:1, exp_e:32'hFF01FF02};
      vecs[3] = '{n:5,  b:{8'hFF, 8'h01, 8'h02, 8'h03, 8'h04, 56'h0}, bad:12'h000,
                  gap:1, ev:1, ee:0, exp_e:32'h01020304};
      vecs[4] = '{n:10, b:{8'hFF, 8'h01, 8'h02, 8'h03, 8'h04, 8'hFF, 8'h09, 8'h08, 8'h07, 8'h06, 16'h0},
                  bad:12'h000, gap:0, ev:2, ee:0, exp_e:32'h09080706};

      // Reset state
      repeat (4) @(negedge CLK);
      check("reset_E", {E1, E2, E3, E4}, 32'h0);
      check("reset_valid", {31'd0, FRAME_VALID}, 32'd0);
      check("reset_err", {31'd0, FRAME_ERR}, 32'd0);
      RST = 1'b0;
      idle_bits(2);

      // Table-driven frame vectors
      foreach (vecs[v]) begin
         stim_b.delete(); stim_bad.delete(); stim_gap.delete();
         for (int i = 0; i < vecs[v].n; i++) begin
            stim_b.push_back(vecs[v].b[i]);
            stim_bad.push_back(vecs[v].bad[i]);
            stim_gap.push_back(vecs[v].gap);
         end
         run_stream(dv, de);
         check($sformatf("vec%0d_valid_count", v), dv, vecs[v].ev);
         check($sformatf("vec%0d_err_count", v), de, vecs[v].ee);
         check($sformatf("vec%0d_E", v), {E1, E2, E3, E4}, vecs[v].exp_e);
         if (v == 0) begin
            diff = last_valid_cyc - last_send_end;
            check("vec0_valid_latency_window", {31'd0, (diff >= -CPB && diff <= 0)}, 32'd1);
         end
         if (v == 4 && got_q.size() == 2)
            check("vec4_first_frame", got_q[0], 32'h01020304);
      end
      exp_cur = 32'h09080706;

      // Inter-byte timeout: header + one byte, then line idle
      begin
         int v0, e0;
         v0 = n_valid; e0 = n_err;
         send_byte(8'hFF, 1'b1);
         idle_bits(1);
         send_byte(8'h11, 1'b1);
         idle_bits(TOB + 5);
         check("timeout_err_count", n_err - e0, 1);
         check("timeout_valid_count", n_valid - v0, 0);
         diff = last_err_cyc - last_send_end;
         check("timeout_timing_window",
               {31'd0, (diff >= TOB*CPB - CPB && diff <= TOB*CPB + CPB/2)}, 32'd1);
         check("timeout_E_hold", {E1, E2, E3, E4}, exp_cur);
         v0 = n_valid; e0 = n_err;
         send_frame(32'h05060708);
         idle_bits(3);
         check("after_timeout_valid", n_valid - v0, 1);
         check("after_timeout_E", {E1, E2, E3, E4}, 32'h05060708);
         exp_cur = 32'h05060708;
      end

      // Short low glitch while idle, then reset in the middle of a byte
      begin
         int v0, e0;
         v0 = n_valid; e0 = n_err;
         RX = 1'b0;
         repeat (CPB/4) @(negedge CLK);
         idle_bits(3);
         check("glitch_no_valid", n_valid - v0, 0);
         check("glitch_no_err", n_err - e0, 0);
         send_frame(32'hA1A2A3A4);
         idle_bits(2);
         check("post_glitch_E", {E1, E2, E3, E4}, 32'hA1A2A3A4);
         send_byte(8'hFF, 1'b1);
         send_byte(8'hB1, 1'b1);
         RX = 1'b0;
         repeat (CPB + 3*CPB + CPB/2) @(negedge CLK);
         RST = 1'b1;
         @(negedge CLK);
         check("midbyte_reset_E", {E1, E2, E3, E4}, 32'h0);
         check("midbyte_reset_flags", {30'd0, FRAME_VALID, FRAME_ERR}, 32'd0);
         RST = 1'b0;
         idle_bits(3);
         v0 = n_valid; e0 = n_err;
         send_frame(32'hC1C2C3C4);
         idle_bits(TOB + 5);
         check("post_reset_valid", n_valid - v0, 1);
         check("post_reset_err", n_err - e0, 0);
         check("post_reset_E", {E1, E2, E3, E4}, 32'hC1C2C3C4);
         exp_cur = 32'hC1C2C3C4;
      end

      // Random byte streams against the reference model
      for (int r = 0; r < 6; r++) begin
         int n;
         stim_b.delete(); stim_bad.delete(); stim_gap.delete();
         n = $urandom_range(12, 6);
         for (int i = 0; i < n; i++) begin
            stim_b.push_back(($urandom_range(9, 0) < 4) ? 8'hFF : 8'($urandom));
            stim_bad.push_back($urandom_range(9, 0) == 0);
            stim_gap.push_back($urandom_range(3, 0));
         end
         model(ee);
         run_stream(dv, de);
         check($sformatf("rand%0d_valid_count", r), dv, exp_q.size());
         check($sformatf("rand%0d_err_count", r), de, ee);
         for (int k = 0; k < exp_q.size() && k < got_q.size(); k++)
            check($sformatf("rand%0d_frame%0d", r, k), got_q[k], exp_q[k]);
         if (exp_q.size() > 0) exp_cur = exp_q[exp_q.size()-1];
         check($sformatf("rand%0d_final_E", r), {E1, E2, E3, E4}, exp_cur);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
